// File: rtl/input_conditioner_pkg.sv
// Shared types and default constants for the input conditioner.
package input_conditioner_pkg;

   typedef enum logic [1:0] {
      S_LOW  = 2'd0,
      P_HIGH = 2'd1,
      S_HIGH = 2'd2,
      P_LOW  = 2'd3
   } chan_state_t;

   localparam int DEF_TICK_DIV     = 50000;
   localparam int DEF_STABLE_COUNT = 10;

endpackage

// File: rtl/input_conditioner_chan.sv
// One debounced channel: 2-flop synchronizer, qualification FSM, agreement counter, edge pulses.
// Edge registers exist only when INPUT_CONDITIONER_EDGE_EN is defined.
module input_conditioner_chan
   import input_conditioner_pkg::*;
#(
   parameter int STABLE_COUNT = DEF_STABLE_COUNT
) (
   input  logic clk,
   input  logic rst,
   input  logic in_raw,
   input  logic tick,
   output logic level,
   output logic rise,
   output logic fall
);

   localparam int             CW       = $clog2(STABLE_COUNT + 1);
   localparam logic [CW-1:0]  CNT_LAST = CW'(STABLE_COUNT - 1);
   localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

   logic          sync1_r;
   logic          sync2_r;
   chan_state_t   state_r;
   logic [CW-1:0] cnt_r;
   logic          level_r;
`ifdef INPUT_CONDITIONER_EDGE_EN
   logic          rise_r;
   logic          fall_r;
`endif

   // Synchronizer plus qualification FSM; the accepting tick moves straight to the stable state.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_r <= 1'b0;
         sync2_r <= 1'b0;
         state_r <= S_LOW;
         cnt_r   <= '0;
         level_r <= 1'b0;
`ifdef INPUT_CONDITIONER_EDGE_EN
         rise_r  <= 1'b0;
         fall_r  <= 1'b0;
`endif
      end else begin
         sync1_r <= in_raw;
         sync2_r <= sync1_r;
`ifdef INPUT_CONDITIONER_EDGE_EN
         rise_r  <= 1'b0;
         fall_r  <= 1'b0;
`endif
         case (state_r)
            S_LOW: begin
               if (sync2_r) begin
                  state_r <= P_HIGH;
                  cnt_r   <= '0;
               end
            end
            P_HIGH: begin
               if (!sync2_r) begin
                  state_r <= S_LOW;
                  cnt_r   <= '0;
               end else if (tick) begin
                  if (cnt_r == CNT_LAST) begin
                     state_r <= S_HIGH;
                     cnt_r   <= '0;
                     level_r <= 1'b1;
`ifdef INPUT_CONDITIONER_EDGE_EN
                     rise_r  <= 1'b1;
`endif
                  end else begin
                     cnt_r <= cnt_r + CNT_ONE;
                  end
               end
            end
            S_HIGH: begin
               if (!sync2_r) begin
                  state_r <= P_LOW;
                  cnt_r   <= '0;
               end
            end
            P_LOW: begin
               if (sync2_r) begin
                  state_r <= S_HIGH;
                  cnt_r   <= '0;
               end else if (tick) begin
                  if (cnt_r == CNT_LAST) begin
                     state_r <= S_LOW;
                     cnt_r   <= '0;
                     level_r <= 1'b0;
`ifdef INPUT_CONDITIONER_EDGE_EN
                     fall_r  <= 1'b1;
`endif
                  end else begin
                     cnt_r <= cnt_r + CNT_ONE;
                  end
               end
            end
            default: begin
               state_r <= S_LOW;
               cnt_r   <= '0;
               level_r <= 1'b0;
            end
         endcase
      end
   end

   assign level = level_r;
`ifdef INPUT_CONDITIONER_EDGE_EN
   assign rise  = rise_r;
   assign fall  = fall_r;
`else
   assign rise  = 1'b0;
   assign fall  = 1'b0;
`endif

endmodule

// File: rtl/input_conditioner.sv
// Multi-channel switch debouncer: shared sample-tick prescaler feeding WIDTH independent channels.
// Optional rise/fall pulses are enabled by defining INPUT_CONDITIONER_EDGE_EN.
module input_conditioner
   import input_conditioner_pkg::*;
#(
   parameter int WIDTH        = 21,
   parameter int TICK_DIV     = DEF_TICK_DIV,
   parameter int STABLE_COUNT = DEF_STABLE_COUNT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_raw,
   output logic [WIDTH-1:0] level,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall,
   output logic             tick
);

   localparam int            PW       = $clog2(TICK_DIV);
   localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
   localparam logic [PW-1:0] PRE_ONE  = PW'(1);

   logic [PW-1:0] pre_r;
   logic          tick_r;

   // Prescaler; tick is registered so it is high exactly while the count sits at its last value.
   always_ff @(posedge clk) begin
      if (rst) begin
         pre_r  <= '0;
         tick_r <= 1'b0;
      end else if (pre_r == PRE_LAST) begin
         pre_r  <= '0;
         tick_r <= 1'b0;
      end else begin
         pre_r  <= pre_r + PRE_ONE;
         tick_r <= (pre_r == (PRE_LAST - PRE_ONE));
      end
   end

   assign tick = tick_r;

   for (genvar g = 0; g < WIDTH; g++) begin : g_chan
      input_conditioner_chan #(
         .STABLE_COUNT(STABLE_COUNT)
      ) u_chan (
         .clk   (clk),
         .rst   (rst),
         .in_raw(in_raw[g]),
         .tick  (tick_r),
         .level (level[g]),
         .rise  (rise[g]),
         .fall  (fall[g])
      );
   end

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner (WIDTH=4, TICK_DIV=4, STABLE_COUNT=3).
// Directed scenarios with literal expectations plus a randomized run against a behavioural model.
module tb_input_conditioner;

   localparam int W  = 4;
   localparam int TD = 4;
   localparam int SC = 3;
`ifdef INPUT_CONDITIONER_EDGE_EN
   localparam int EDGE_EN = 1;
`else
   localparam int EDGE_EN = 0;
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [W-1:0] in_raw = '0;
   logic [W-1:0] level;
   logic [W-1:0] rise;
   logic [W-1:0] fall;
   logic         tick;

   input_conditioner #(.WIDTH(W), .TICK_DIV(TD), .STABLE_COUNT(SC)) dut (
      .clk   (clk),
      .rst   (rst),
      .in_raw(in_raw),
      .level (level),
      .rise  (rise),
      .fall  (fall),
      .tick  (tick)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Behavioural model: delayed sample, accepted level, pending flag and ticks seen while pending.
   logic [W-1:0] m_s1 = '0, m_s2 = '0, m_lvl = '0, m_pend = '0, m_rise = '0, m_fall = '0;
   int           m_pc = 0;
   int           m_cnt [W];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic model_edge();
      logic         tk;
      logic [W-1:0] smp;
      tk  = (m_pc == TD - 1);
      smp = m_s2;
      m_rise = '0;
      m_fall = '0;
      if (rst) begin
         m_s1 = '0; m_s2 = '0; m_pc = 0; m_lvl = '0; m_pend = '0;
         for (int c = 0; c < W; c++) m_cnt[c] = 0;
      end else begin
         m_s2 = m_s1;
         m_s1 = in_raw;
         m_pc = (m_pc + 1) % TD;
         for (int c = 0; c < W; c++) begin
            if (!m_pend[c]) begin
               if (smp[c] != m_lvl[c]) begin m_pend[c] = 1'b1; m_cnt[c] = 0; end
            end else if (smp[c] == m_lvl[c]) begin
               m_pend[c] = 1'b0; m_cnt[c] = 0;
            end else if (tk) begin
               if (m_cnt[c] + 1 == SC) begin
                  m_lvl[c] = smp[c];
                  if (smp[c]) m_rise[c] = 1'b1; else m_fall[c] = 1'b1;
                  m_pend[c] = 1'b0; m_cnt[c] = 0;
               end else begin
                  m_cnt[c]++;
               end
            end
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      model_edge();
      chk("level", 32'(level), 32'(m_lvl));
      chk("tick",  32'(tick),  32'(m_pc == TD - 1));
      chk("rise",  32'(rise),  EDGE_EN != 0 ? 32'(m_rise) : 32'd0);
      chk("fall",  32'(fall),  EDGE_EN != 0 ? 32'(m_fall) : 32'd0);
      chk("rise_fall_excl", 32'(rise & fall), 32'd0);
   endtask

   task automatic do_reset(input logic [W-1:0] hold);
      rst = 1'b1;
      in_raw = hold;
      step();
      step();
      rst = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int first_seen, n_rise, n_fall, last_tick, other_bad;

      // Reset state.
      do_reset(4'b0000);
      chk("reset_level", 32'(level), 32'd0);
      chk("reset_rise",  32'(rise),  32'd0);
      chk("reset_fall",  32'(fall),  32'd0);
      chk("reset_tick",  32'(tick),  32'd0);

      // Clean step on channel 0, level appears 12 edges after release.
      in_raw = 4'b0001;
      first_seen = 0; n_rise = 0; last_tick = 0; other_bad = 0;
      for (int n = 1; n <= 40; n++) begin
         step();
         if (level[0] && first_seen == 0) first_seen = n;
         if (rise[0]) n_rise++;
         if (level[3:1] != 3'b000 || rise[3:1] != 3'b000) other_bad++;
         if (tick) begin
            if (last_tick != 0) chk("tick_period", 32'(n - last_tick), 32'd4);
            else chk("first_tick", 32'(n), 32'd3);
            last_tick = n;
         end
      end
      chk("step_latency", 32'(first_seen), 32'd12);
      chk("step_rise_count", 32'(n_rise), 32'(EDGE_EN));
      chk("step_others_quiet", 32'(other_bad), 32'd0);

      // Release from S_HIGH on channel 2.
      in_raw = 4'b0101;
      for (int n = 0; n < 20; n++) step();
      chk("ch2_high", 32'(level[2]), 32'd1);
      in_raw = 4'b0001;
      n_rise = 0; n_fall = 0;
      for (int n = 0; n < 25; n++) begin
         step();
         if (fall[2]) n_fall++;
         if (rise[2]) n_rise++;
      end
      chk("ch2_low", 32'(level[2]), 32'd0);
      chk("ch2_fall_count", 32'(n_fall), 32'(EDGE_EN));
      chk("ch2_no_rise", 32'(n_rise), 32'd0);

      // Abort: sample reverts in the cycle of the third qualifying tick.
      do_reset(4'b0000);
      in_raw = 4'b1000;
      for (int n = 0; n < 9; n++) step();
      in_raw = 4'b0000;
      n_rise = 0; other_bad = 0;
      for (int n = 0; n < 15; n++) begin
         step();
         if (level[3]) other_bad++;
         if (rise[3]) n_rise++;
      end
      chk("abort_level", 32'(other_bad), 32'd0);
      chk("abort_rise", 32'(n_rise), 32'd0);

      // Bounce on channel 1: toggle every 3 cycles for 40 cycles, then settle high.
      do_reset(4'b0000);
      other_bad = 0; n_rise = 0; n_fall = 0;
      for (int i = 0; i < 40; i++) begin
         in_raw[1] = ((i / 3) % 2 == 0);
         step();
         if (level[1] || rise[1] || fall[1]) other_bad++;
      end
      in_raw[1] = 1'b1;
      for (int i = 0; i < 30; i++) begin
         step();
         if (rise[1]) n_rise++;
         if (fall[1]) n_fall++;
      end
      chk("bounce_quiet", 32'(other_bad), 32'd0);
      chk("bounce_rise_count", 32'(n_rise), 32'(EDGE_EN));
      chk("bounce_fall_count", 32'(n_fall), 32'd0);
      chk("bounce_level", 32'(level[1]), 32'd1);

      // Reset in the middle of a pending change after two ticks.
      do_reset(4'b0000);
      in_raw = 4'b0001;
      for (int n = 0; n < 8; n++) step();
      rst = 1'b1;
      step();
      chk("midreset_level", 32'(level), 32'd0);
      chk("midreset_rise",  32'(rise),  32'd0);
      chk("midreset_tick",  32'(tick),  32'd0);
      rst = 1'b0;
      first_seen = 0; n_rise = 0;
      for (int n = 1; n <= 20; n++) begin
         step();
         if (level[0] && first_seen == 0) first_seen = n;
         if (rise[0]) n_rise++;
      end
      chk("midreset_latency", 32'(first_seen), 32'd12);
      chk("midreset_rise_count", 32'(n_rise), 32'(EDGE_EN));

      // Randomized run, alternating calm and bouncy periods, with occasional resets.
      for (int i = 0; i < 4000; i++) begin
         rst = ($urandom_range(0, 499) == 0);
         for (int b = 0; b < W; b++) begin
            if ($urandom_range(0, ((i / 500) % 2 == 0) ? 29 : 3) == 0) in_raw[b] = ~in_raw[b];
         end
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 The block SHALL have parameter WIDTH, default 21, giving the number of independent input channels.
REQ-002 The block SHALL have parameter TICK_DIV, default 50000, giving the sample-tick period in clk cycles (range 2..2^20).
REQ-003 The block SHALL have parameter STABLE_COUNT, default 10, giving the consecutive agreeing ticks needed to accept a new level (range 1..255).
REQ-004 clk  input  1  sole clock; all state on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 in_raw  input  WIDTH  asynchronous switch/button levels, one bit per channel.
REQ-007 level  output  WIDTH  debounced level per channel.
REQ-008 rise  output  WIDTH  one-cycle pulse per channel on an accepted 0->1 change.
REQ-009 fall  output  WIDTH  one-cycle pulse per channel on an accepted 1->0 change.
REQ-010 tick  output  1  prescaler strobe, high one cycle every TICK_DIV cycles.

Function
REQ-011 Each in_raw bit SHALL pass through a 2-flop synchronizer before any other use; "sample" means the second flop's output.
REQ-012 A shared prescaler SHALL count 0..TICK_DIV-1 and wrap to 0; tick SHALL be high exactly in the cycle the count equals TICK_DIV-1.
REQ-013 Each channel SHALL run an FSM with states S_LOW, P_HIGH, S_HIGH, P_LOW and a per-channel agreement counter of ceil(log2(STABLE_COUNT+1)) bits.
REQ-014 S_LOW: sample=1 -> P_HIGH with counter 0; otherwise stay.
REQ-015 P_HIGH: sample=0 in any cycle -> S_LOW with counter cleared; tick with sample=1 -> counter+1; when counter reaches STABLE_COUNT -> S_HIGH.
REQ-016 S_HIGH/P_LOW SHALL mirror REQ-014/015 with polarities swapped.
REQ-017 Sample reversal and tick in the same cycle SHALL count as reversal: abort, no increment.
REQ-018 level SHALL be a registered bit: 1 in S_HIGH and P_LOW, 0 in S_LOW and P_HIGH.
REQ-019 rise/fall SHALL be registered and high only in the first cycle level shows the new value; never both high on one channel.
REQ-020 Latency from the first cycle a change is visible in the sample to the level update SHALL be the cycle after the STABLE_COUNT-th qualifying tick.
REQ-021 The counter SHALL never exceed STABLE_COUNT and SHALL never wrap.
REQ-022 Channels SHALL be fully independent except for the shared tick.

Reset
REQ-023 With rst high at a clk edge: synchronizer flops 0, prescaler 0, every FSM S_LOW, counters 0, level 0, rise 0, fall 0, tick 0.
REQ-024 Reset asserted mid-pending SHALL discard the pending change with no rise/fall pulse.
REQ-025 After reset release, a channel held at 1 SHALL give level=1 with one rise pulse after the normal REQ-020 latency.

Configuration
REQ-026 With INPUT_CONDITIONER_EDGE_EN defined, rise/fall SHALL behave per REQ-019; without it, rise and fall SHALL be tied to 0 and the edge registers SHALL be absent. level and tick are unaffected.

Structure
REQ-027 Package input_conditioner_pkg SHALL hold the channel state enum (S_LOW, P_HIGH, S_HIGH, P_LOW) and the default constants for TICK_DIV and STABLE_COUNT.
REQ-028 Sub-module input_conditioner_chan SHALL implement one channel: synchronizer, FSM, counter and edge registers. The top SHALL implement the prescaler and instantiate WIDTH channels.

Verification (bench uses WIDTH=4, TICK_DIV=4, STABLE_COUNT=3)
REQ-029 Clean step: in_raw[0] 0->1 and held -> level[0]=1 the cycle after the 3rd tick with sample=1, with a single rise[0] pulse in that cycle; other channels stay 0.
REQ-030 Bounce: in_raw[1] toggles every 3 cycles for 40 cycles, then settles at 1 -> no level/rise/fall activity until 3 qualifying ticks after settling, then exactly one rise[1].
REQ-031 Abort on tick: sample reverts in the same cycle as the 3rd tick -> level unchanged, counter 0, no pulse.
REQ-032 Release: in_raw[2] 1->0 from S_HIGH -> fall[2] is a single pulse, level[2]=0 at the same latency; prescaler wrap gives tick period exactly 4.
REQ-033 Reset mid-pending: rst for 1 cycle during P_HIGH after 2 ticks -> all outputs 0 next cycle; input still high -> rise after a full 3-tick qualification.
REQ-034 Build without INPUT_CONDITIONER_EDGE_EN and rerun REQ-029 -> level identical; rise and fall constantly 0.
